// File: rtl/buffer_loader.sv
// buffer_loader: parses framed host load commands from a byte stream into
// tag-addressed command-buffer writes.
module buffer_loader #(
  parameter int MEM_DEPTH     = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int BUFFER_LENGTH = MEM_DEPTH + 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic                     buffer_full,
  output logic                     buffer_write_enable,
  output logic [BUFFER_LENGTH-1:0] buffer_write_addr,
  output logic [DATA_WIDTH-1:0]    buffer_write_data,
  output logic                     busy,
  output logic                     frame_error
);
  localparam int BYTES = DATA_WIDTH / 8;
  typedef enum logic [2:0] {HDR, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, WRITE} state_t;
  state_t                   r_state;
  logic [4:0]               r_tag;
  logic [7:0]               r_lo;
  logic [MEM_DEPTH-1:0]     r_offset;
  logic [15:0]              r_remaining;
  logic [DATA_WIDTH-1:0]    r_shift;
  logic [3:0]               r_byte_cnt;
  logic [BUFFER_LENGTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_rx_ready;
  logic                     r_busy;
  logic                     r_frame_error;
  logic                     w_take;
  logic [15:0]              w_count;
  logic [DATA_WIDTH-1:0]    w_word;
  assign w_take  = rx_valid & r_rx_ready;
  assign w_count = {rx_data, r_lo};
  // little-endian assembly: each new byte enters at the top and slides down
  assign w_word  = (r_shift >> 8) | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 8));
  assign rx_ready            = r_rx_ready;
  assign busy                = r_busy;
  assign frame_error         = r_frame_error;
  assign buffer_write_addr   = r_addr;
  assign buffer_write_data   = r_data;
  assign buffer_write_enable = (r_state == WRITE) & ~buffer_full;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= HDR;
      r_tag         <= '0;
      r_lo          <= '0;
      r_offset      <= '0;
      r_remaining   <= '0;
      r_shift       <= '0;
      r_byte_cnt    <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_rx_ready    <= 1'b1;
      r_busy        <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= 1'b0;
      case (r_state)
        HDR: if (w_take) begin
          if (rx_data[7:5] == 3'b101 && rx_data[4:0] != 5'd0) begin
            r_tag   <= rx_data[4:0];
            r_busy  <= 1'b1;
            r_state <= ADDR_LO;
          end else r_frame_error <= 1'b1;
        end
        ADDR_LO: if (w_take) begin
          r_lo    <= rx_data;
          r_state <= ADDR_HI;
        end
        ADDR_HI: if (w_take) begin
          r_offset <= MEM_DEPTH'({rx_data, r_lo});
          r_state  <= CNT_LO;
        end
        CNT_LO: if (w_take) begin
          r_lo    <= rx_data;
          r_state <= CNT_HI;
        end
        CNT_HI: if (w_take) begin
          r_remaining <= w_count;
          r_byte_cnt  <= '0;
          r_busy      <= w_count != 16'd0;
          r_state     <= (w_count == 16'd0) ? HDR : DATA;
        end
        DATA: if (w_take) begin
          r_shift    <= w_word;
          r_byte_cnt <= r_byte_cnt + 4'd1;
          if (r_byte_cnt == 4'(BYTES - 1)) begin
            r_byte_cnt <= '0;
            r_addr     <= {r_tag, r_offset};
            r_data     <= w_word;
            r_rx_ready <= 1'b0;
            r_state    <= WRITE;
          end
        end
        WRITE: if (!buffer_full) begin
          r_offset    <= r_offset + 1'b1;
          r_remaining <= r_remaining - 16'd1;
          r_rx_ready  <= 1'b1;
          r_busy      <= r_remaining != 16'd1;
          r_state     <= (r_remaining == 16'd1) ? HDR : DATA;
        end
        default: r_state <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_buffer_loader.sv
// tb_buffer_loader: frame-level reference model against directed and random
// byte streams, with backpressure and mid-frame reset.
module tb_buffer_loader;
  logic        clk = 1'b0, reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, buffer_full = 1'b0;
  logic        rx_ready, buffer_write_enable, busy, frame_error;
  logic [12:0] buffer_write_addr;
  logic [15:0] buffer_write_data;
  buffer_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .buffer_full(buffer_full),
    .buffer_write_enable(buffer_write_enable), .buffer_write_addr(buffer_write_addr),
    .buffer_write_data(buffer_write_data), .busy(busy), .frame_error(frame_error)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, exp_err = 0, err_seen = 0;
  bit bp_arm = 0, rand_full = 0;
  int exp_addr[$], exp_data[$];
  logic [7:0] fr[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_frame(input logic [7:0] f[$]);
    int base, n;
    logic [7:0] h;
    h = f[0];
    if (h[7:5] != 3'b101 || h[4:0] == 5'd0) begin
      exp_err++;
      return;
    end
    base = int'(f[1]) + 256 * int'(f[2]);
    n    = int'(f[3]) + 256 * int'(f[4]);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(int'(h[4:0]) * 256 + (base + i) % 256);
      exp_data.push_back(int'(f[5 + 2 * i]) + 256 * int'(f[6 + 2 * i]));
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done;
    for (int n = 0; n < 1000; n++) begin
      rx_data  = b;
      rx_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
      @(negedge clk);
      done = rx_valid && rx_ready;
      @(posedge clk); #1;
      if (done) return;
    end
    chk("byte_timeout", 1, 0);
  endtask
  task automatic send_frame(input logic [7:0] f[$], input int gap);
    model_frame(f);
    foreach (f[i]) send_byte(f[i], gap);
    rx_valid = 1'b0;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && exp_addr.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", exp_addr.size(), 0);
    chk("busy_end", busy, 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) if (!reset) begin
    if (frame_error) err_seen++;
    if (buffer_write_enable) begin
      if (exp_addr.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        chk("wr_addr", buffer_write_addr, exp_addr.pop_front());
        chk("wr_data", buffer_write_data, exp_data.pop_front());
      end
    end
  end
  initial forever begin
    @(posedge clk); #1;
    if (bp_arm && !rx_ready && !reset) begin
      bp_arm = 0;
      buffer_full = 1'b1;
      repeat (5) begin
        @(negedge clk);
        chk("bp_ready", rx_ready, 0);
        chk("bp_we", buffer_write_enable, 0);
        @(posedge clk); #1;
      end
      buffer_full = 1'b0;
    end else buffer_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [7:0] h;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rx_ready, 1);
    chk("rst_we", buffer_write_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_addr", buffer_write_addr, 0);
    chk("rst_data", buffer_write_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    fr = '{8'hA1, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    send_frame(fr, 0);
    @(negedge clk);
    chk("wr_latency", buffer_write_enable, 1);
    @(posedge clk); #1;
    wait_idle();
    fr = '{8'hA2, 8'hFF, 8'h07, 8'h02, 8'h00, 8'hAA, 8'h00, 8'hBB, 8'h00};
    send_frame(fr, 0);
    wait_idle();
    bp_arm = 1;
    fr = '{8'hA1, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    send_frame(fr, 0);
    wait_idle();
    chk("bp_fired", bp_arm, 0);
    fr = '{8'h41};
    send_frame(fr, 0);
    fr = '{8'hA0};
    send_frame(fr, 0);
    @(negedge clk);
    chk("rej_busy", busy, 0);
    @(posedge clk); #1;
    chk("rej_cnt", err_seen, 2);
    fr = '{8'hA1, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE};
    send_frame(fr, 0);
    wait_idle();
    fr = '{8'hA4, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fr, 40);
    wait_idle();
    fr = '{8'hA3, 8'h05, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    send_frame(fr, 40);
    wait_idle();
    fr = '{8'hA1, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34};
    foreach (fr[i]) send_byte(fr[i], 0);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mrst_ready", rx_ready, 1);
    chk("mrst_we", buffer_write_enable, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", buffer_write_addr, 0);
    chk("mrst_data", buffer_write_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    fr = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'h0D, 8'hF0};
    send_frame(fr, 0);
    wait_idle();
    rand_full = 1;
    for (int k = 0; k < 25; k++) begin
      fr = {};
      if ($urandom_range(0, 4) == 0) begin
        h = 8'($urandom);
        while (h[7:5] == 3'b101 && h[4:0] != 5'd0) h = 8'($urandom);
        fr.push_back(h);
      end else begin
        fr.push_back({3'b101, 5'($urandom_range(1, 31))});
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
        n = $urandom_range(0, 4);
        fr.push_back(8'(n));
        fr.push_back(8'h00);
        for (int i = 0; i < 2 * n; i++) fr.push_back(8'($urandom));
      end
      send_frame(fr, $urandom_range(0, 30));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    rand_full = 0;
    chk("ferr_total", err_seen, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
